// File: rtl/VX_tcu_pkg.sv
// VX_tcu_pkg: shared state type and shift constants for the TCU alignment scheduler.
package VX_tcu_pkg;
    typedef enum logic {FILL, DRAIN} tcu_align_state_t;
    localparam int TCU_SHIFT_W = 8;
    localparam logic [TCU_SHIFT_W-1:0] TCU_SHIFT_SAT = 8'd255;
endpackage

// File: rtl/VX_tcu_drl_max_exp.sv
// VX_tcu_drl_max_exp: maximum of N exponents and the unsaturated distance of each from it.
//   exps      in  N x WIDTH  exponents
//   max_exp   out WIDTH      largest exponent
//   shift_amt out N x WIDTH  max_exp - exps[i]
module VX_tcu_drl_max_exp #(
    parameter int N     = 4,
    parameter int WIDTH = 8
)(
    input  logic [N*WIDTH-1:0] exps,
    output logic [WIDTH-1:0]   max_exp,
    output logic [N*WIDTH-1:0] shift_amt
);
    always_comb begin
        max_exp = exps[WIDTH-1:0];
        for (int i = 1; i < N; i++)
            max_exp = exps[i*WIDTH +: WIDTH] > max_exp ? exps[i*WIDTH +: WIDTH] : max_exp;
        for (int i = 0; i < N; i++)
            shift_amt[i*WIDTH +: WIDTH] = max_exp - exps[i*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/VX_tcu_drl_shift_sat.sv
// VX_tcu_drl_shift_sat: per-element right-shift max - exp, saturated to the shift range.
//   max_i   in  WIDTH            group maximum exponent
//   exps_i  in  N x WIDTH        exponents of one beat
//   shift_o out N x TCU_SHIFT_W  saturated shift amounts
module VX_tcu_drl_shift_sat
    import VX_tcu_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
)(
    input  logic [WIDTH-1:0]         max_i,
    input  logic [N*WIDTH-1:0]       exps_i,
    output logic [N*TCU_SHIFT_W-1:0] shift_o
);
    logic [WIDTH:0] diff [N];

    // max_i is the group maximum, so the extra bit only ever widens the range, never signs it
    always_comb begin
        for (int i = 0; i < N; i++) begin
            diff[i] = {1'b0, max_i} - {1'b0, exps_i[i*WIDTH +: WIDTH]};
            shift_o[i*TCU_SHIFT_W +: TCU_SHIFT_W] = diff[i] > (WIDTH+1)'(TCU_SHIFT_SAT) ?
                TCU_SHIFT_SAT : TCU_SHIFT_W'(diff[i]);
        end
    end
endmodule

// File: rtl/vx_tcu_drl_align_sched.sv
// vx_tcu_drl_align_sched: buffers a group of exponent beats, then replays them with shifts
// relative to the group-wide maximum exponent.
//   clk, reset            clock, async active-high reset
//   in_valid/in_ready     input beat handshake; in_exps (N x WIDTH), in_last closes group
//   out_valid/out_ready   output beat handshake
//   out_shift             N x 8 saturated shifts; out_max_exp group max; out_last final beat
module vx_tcu_drl_align_sched
    import VX_tcu_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int BEATS = 4
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*WIDTH-1:0]       in_exps,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*TCU_SHIFT_W-1:0] out_shift,
    output logic [WIDTH-1:0]         out_max_exp,
    output logic                     out_last
);
    localparam int CW = $clog2(BEATS) + 1;
    localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1;

    tcu_align_state_t         state_q, state_d;
    logic [N*WIDTH-1:0]       buf_q [BEATS];
    logic [CW-1:0]            wr_cnt_q, rd_cnt_q, cnt_q;
    logic [WIDTH-1:0]         run_max_q, beat_max, grp_max;
    logic [N*TCU_SHIFT_W-1:0] shift;
    logic                     accept, close_grp;

    VX_tcu_drl_max_exp #(.N(N), .WIDTH(WIDTH)) u_max (
        .exps      (in_exps),
        .max_exp   (beat_max),
        .shift_amt ()
    );

    VX_tcu_drl_shift_sat #(.N(N), .WIDTH(WIDTH)) u_sat (
        .max_i   (run_max_q),
        .exps_i  (buf_q[IW'(rd_cnt_q)]),
        .shift_o (shift)
    );

    assign accept    = in_valid && state_q == FILL;
    // a full buffer closes the group regardless of in_last
    assign close_grp = in_last || wr_cnt_q == CW'(BEATS - 1);
    assign grp_max   = wr_cnt_q == '0 ? beat_max : (beat_max > run_max_q ? beat_max : run_max_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (accept && close_grp) ? DRAIN : (out_ready && out_last) ? FILL : state_q;
    end

    always_comb begin
        in_ready    = state_q == FILL;
        out_valid   = state_q == DRAIN;
        out_last    = out_valid && rd_cnt_q == cnt_q - CW'(1);
        out_max_exp = out_valid ? run_max_q : '0;
        out_shift   = out_valid ? shift : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            cnt_q     <= '0;
            run_max_q <= '0;
            for (int b = 0; b < BEATS; b++) buf_q[b] <= '0;
        end else begin
            if (accept) begin
                buf_q[IW'(wr_cnt_q)] <= in_exps;
                run_max_q            <= grp_max;
                wr_cnt_q             <= wr_cnt_q + CW'(1);
                if (close_grp) begin
                    cnt_q    <= wr_cnt_q + CW'(1);
                    rd_cnt_q <= '0;
                end
            end
            if (out_valid && out_ready) begin
                rd_cnt_q <= rd_cnt_q + CW'(1);
                if (out_last) wr_cnt_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vx_tcu_drl_align_sched.sv
// tb_vx_tcu_drl_align_sched: scoreboard bench for the exponent-alignment scheduler.
module tb_vx_tcu_drl_align_sched;
    typedef struct {
        logic [31:0] sh;
        logic [7:0]  mx;
        logic        lst;
    } exp_t;

    logic        clk, reset;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [31:0] in_exps, out_shift;
    logic [7:0]  out_max_exp;
    logic        w_in_valid, w_in_ready, w_in_last, w_out_valid, w_out_ready, w_out_last;
    logic [43:0] w_in_exps;
    logic [31:0] w_out_shift;
    logic [10:0] w_out_max_exp;

    exp_t sb[$];
    int   checks = 0;
    int   errs   = 0;

    vx_tcu_drl_align_sched #(.N(4), .WIDTH(8), .BEATS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_exps(in_exps), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_shift(out_shift), .out_max_exp(out_max_exp), .out_last(out_last)
    );

    vx_tcu_drl_align_sched #(.N(4), .WIDTH(11), .BEATS(4)) dut11 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_exps(w_in_exps), .in_last(w_in_last), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_shift(w_out_shift), .out_max_exp(w_out_max_exp), .out_last(w_out_last)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] sat(input int d);
        return d > 255 ? 8'd255 : 8'(d);
    endfunction

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_beat", 1, 0);
            else begin
                e = sb.pop_front();
                check("shift", out_shift, e.sh);
                check("max", out_max_exp, e.mx);
                check("last", out_last, e.lst);
            end
        end
    end

    task automatic send_beat(input logic [31:0] e, input logic l);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1;
        in_exps  = e;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic run_group(input logic [31:0] g [4], input int k, input bit use_last);
        int   m = 0;
        exp_t x;
        for (int b = 0; b < k; b++)
            for (int i = 0; i < 4; i++)
                if (int'(g[b][i*8 +: 8]) > m) m = int'(g[b][i*8 +: 8]);
        for (int b = 0; b < k; b++) begin
            for (int i = 0; i < 4; i++) x.sh[i*8 +: 8] = sat(m - int'(g[b][i*8 +: 8]));
            x.mx  = 8'(m);
            x.lst = (b == k - 1);
            sb.push_back(x);
        end
        for (int b = 0; b < k; b++) send_beat(g[b], use_last && b == k - 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] g [4];
        logic [31:0] sh0;
        logic [7:0]  mx0;
        logic        l0;
        reset = 1; in_valid = 0; in_exps = 0; in_last = 0; out_ready = 1;
        w_in_valid = 0; w_in_exps = 0; w_in_last = 0; w_out_ready = 1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_shift", out_shift, 0);
        check("rst_out_max", out_max_exp, 0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        // single beat with ties and a zero element
        g[0] = pk(10, 3, 10, 0);
        run_group(g, 1, 1);
        check("t1_out_valid_next", out_valid, 1);
        check("t1_in_ready_busy", in_ready, 0);
        @(posedge clk); #1;
        check("t1_in_ready_back", in_ready, 1);
        check("t1_out_valid_done", out_valid, 0);
        check("t1_sb_empty", sb.size(), 0);

        // max arrives mid-group
        g[0] = pk(1, 2, 3, 4); g[1] = pk(20, 5, 5, 5); g[2] = pk(7, 7, 7, 7);
        run_group(g, 3, 1);
        wait_drain();

        // forced close after a full buffer, in_last never raised
        g[0] = pk(0, 0, 0, 0); g[1] = pk(3, 1, 4, 1); g[2] = pk(5, 9, 2, 6); g[3] = pk(2, 7, 1, 8);
        run_group(g, 4, 0);
        wait_drain();

        // backpressure during the second output beat
        g[0] = pk(30, 1, 2, 3); g[1] = pk(4, 40, 5, 6); g[2] = pk(0, 0, 0, 0);
        run_group(g, 3, 1);
        @(posedge clk); #1;
        out_ready = 0;
        sh0 = out_shift; mx0 = out_max_exp; l0 = out_last;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_exps = $urandom;
            check("bp_shift_hold", out_shift, sh0);
            check("bp_max_hold", out_max_exp, mx0);
            check("bp_last_hold", out_last, l0);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        wait_drain();

        // all-zero group
        g[0] = pk(0, 0, 0, 0);
        run_group(g, 1, 1);
        wait_drain();

        // wide exponents exercise saturation at exactly and above 255
        w_in_valid = 1;
        w_in_exps  = {11'd1999, 11'd1745, 11'd0, 11'd2000};
        w_in_last  = 1;
        @(posedge clk); #1;
        w_in_valid = 0; w_in_last = 0;
        check("w11_valid", w_out_valid, 1);
        check("w11_shift", w_out_shift,
              {sat(2000 - 1999), sat(2000 - 1745), sat(2000 - 0), sat(2000 - 2000)});
        check("w11_max", w_out_max_exp, 11'd2000);
        check("w11_last", w_out_last, 1);
        @(posedge clk); #1;
        check("w11_in_ready", w_in_ready, 1);

        // reset during drain discards the rest of the group
        g[0] = pk(9, 1, 2, 3); g[1] = pk(4, 5, 6, 7);
        run_group(g, 2, 1);
        @(posedge clk); #3;
        reset = 1;
        sb.delete();
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_out_shift", out_shift, 0);
        check("mid_rst_out_max", out_max_exp, 0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        g[0] = pk(5, 5, 5, 5);
        run_group(g, 1, 1);
        wait_drain();

        repeat (2) @(posedge clk);
        #1;
        check("final_sb_empty", sb.size(), 0);
        check("final_idle", out_valid, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/vx_tcu_drl_align_sched.md
# VX_tcu_drl_align_sched

Multi-beat exponent-alignment scheduler for the TCU dot-product reduction lane. It accepts a product group of up to BEATS beats, each carrying N exponents, and tracks the running maximum exponent across the whole group. After the group closes it replays every stored beat with per-element right-shift amounts relative to that group-wide maximum. It sits between the multiplier exponent stage and the mantissa aligner, so alignment is correct across K-depth larger than one beat.

## Interface
- N, 4: exponents per beat.
- WIDTH, 8: exponent width (unsigned, biased).
- BEATS, 4: maximum beats per group (≥1).
- clk  in  1  clock.
- reset  in  1  reset; one clock; asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  scheduler can accept a beat.
- in_exps  in  N×WIDTH  beat exponents.
- in_last  in  1  beat closes the group.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_shift  out  N×8  per-element shift = group_max − exp, saturated to 255.
- out_max_exp  out  WIDTH  group-wide maximum exponent.
- out_last  out  1  final beat of group.

## Operation
- States: FILL, DRAIN. Reset → FILL.
- FILL: in_ready=1, out_valid=0. On in_valid&in_ready:
  - store beat at buffer[wr_cnt];
  - run_max ← (wr_cnt==0) ? beat_max : max(run_max, beat_max);
  - wr_cnt++.
  - Close the group when in_last=1, or when wr_cnt reaches BEATS−1 before the increment (forced close; in_last is ignored).
  - On close: latch count=wr_cnt+1, set rd_cnt=0, go DRAIN.
- DRAIN: in_ready=0. out_valid=1.
  - out_shift[i] = clamp(run_max − buffer[rd_cnt][i], 255). Compute the difference at WIDTH+1 bits; never negative.
  - out_max_exp=run_max. out_last=(rd_cnt==count−1).
  - On out_valid&out_ready: rd_cnt++. If out_last, clear wr_cnt and go FILL.
- Output order is the input order; no reordering.
- Equal exponents produce shift 0 for every tied element.
- All-zero exponents give run_max=0 and all shifts 0.
- Groups do not overlap: the next group's first beat cannot be accepted until the cycle after the out_last handshake.
- Asynchronous reset at any point, including mid-FILL or mid-DRAIN, discards the partial group. No output is emitted for it.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_shift=0, out_max_exp=0. Internal counters and run_max are 0.
- Closing beat accepted at cycle t → out_valid=1 at t+1. First output beat is visible combinationally from registered state at t+1.
- Throughput: one beat per cycle in each state. A group of k beats occupies 2k cycles with out_ready held high.
- While out_valid=1 and out_ready=0, out_shift, out_max_exp and out_last hold stable.
- in_exps is sampled only on the accept edge. Changes while in_ready=0 are ignored.
- No combinational path from out_ready to in_ready.

## Structure
- VX_tcu_pkg holds:
  - the state enum tcu_align_state_t (FILL, DRAIN);
  - the constant TCU_SHIFT_W=8 and the saturation value 255.
- Beat max: instantiate the existing VX_tcu_drl_max_exp (N, WIDTH). Use its max_exp only; leave shift_amt unconnected.
- Sub-module VX_tcu_drl_shift_sat computes the N-wide clamp(max − exp, 255) using WIDTH+1-bit subtract.
- Buffer: BEATS×N×WIDTH register array. Counter width is $clog2(BEATS)+1.

## Test plan
- Single beat {10,3,10,0}, in_last=1 → one output beat: shift {0,7,0,10}, max 10, out_last=1. in_ready returns to 1 the cycle after the handshake.
- Three beats {1,2,3,4}, {20,5,5,5}, {7,7,7,7} with in_last on the third → max 20 on all beats. Shifts {19,18,17,16}, {0,15,15,15}, {13,13,13,13}; out_last only on the third.
- Four beats, in_last never asserted (BEATS=4) → forced close after beat 4; four output beats; out_last on the fourth.
- Backpressure: out_ready=0 for 3 cycles during the second output beat → outputs hold stable; in_ready stays 0; no beat is lost or duplicated.
- WIDTH=11, beat {2000,0,1745,1999} → shift {0,255,255,1}, max 2000.
- Assert reset during DRAIN after one output beat → all outputs take their reset values immediately. The next group {5,5,5,5} alone yields shift {0,0,0,0}, max 5.
